palindrome_generator: RTL and testbench

Sequential N-bit palindrome generator. It accepts a half-word over a valid/ready handshake and mirrors it bit-serially into the lower half of an output word, one bit per clock. It then presents the completed palindrome over a second valid/ready handshake. It is the source-side counterpart to the team's combinational palindrome checker: every word it emits must be classified as a palindrome by that checker.

---
 rtl/palindrome_pkg.sv | 26 ++
 rtl/palindrome_if.sv | 27 ++
 rtl/palindrome_mirror_shift.sv | 48 ++++
 rtl/palindrome_generator.sv | 81 ++++++++
 tb/tb_palindrome_generator.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the palindrome generator and its users.
package palindrome_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Widest word is_palindrome() can inspect.
   localparam int MAX_W = 64;

   function automatic int pal_half(input int width);
      return width / 2;
   endfunction

   function automatic logic is_palindrome(input logic [MAX_W-1:0] word, input int width);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_W / 2; i++) begin
         if (i < width / 2 && word[i] != word[width-1-i]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/palindrome_if.sv
// Input/output handshakes of the palindrome generator.
interface palindrome_if
   import palindrome_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int HALF = pal_half(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [HALF-1:0]  half_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             busy;

   modport master (
      output in_valid, half_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, half_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );

endinterface

// File: rtl/palindrome_mirror_shift.sv
// Bit-serial mirror: shifts the half-word LSB first into a lower-half register,
// producing the bit-reversed half after HALF steps.
module palindrome_mirror_shift
   import palindrome_pkg::*;
#(
   parameter int HALF = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [HALF-1:0] din,
   output logic            last,
   output logic [HALF-1:0] mirror
);
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [HALF-1:0]  work;
   logic [HALF-1:0]  lower;
   logic [CNT_W-1:0] cnt;
   logic [HALF:0]    shifted;

   // The first bit shifted in ends at the top, so the result is reversed.
   assign shifted = {lower, work[0]};
   assign mirror  = shifted[HALF-1:0];
   assign last    = (cnt == CNT_W'(HALF - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (step && !last) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         work  <= din;
         lower <= '0;
      end else if (step) begin
         work  <= work >> 1;
         lower <= mirror;
      end
   end

endmodule

// File: rtl/palindrome_generator.sv
// Builds an N-bit palindrome from a half-word: accept, mirror bit-serially,
// then hold the word until the consumer takes it.
module palindrome_generator
   import palindrome_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   palindrome_if.slave   bus
);
   localparam int HALF = pal_half(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             last;
   logic [HALF-1:0]  upper;
   logic [HALF-1:0]  mirror;
   logic [WIDTH-1:0] data_q;

   palindrome_mirror_shift #(.HALF(HALF)) u_mirror (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .din    (bus.half_in),
      .last   (last),
      .mirror (mirror)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (last) state_nxt = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (load) upper <= bus.half_in;
   end

   // Loaded only on the final shift; keeps the last delivered word otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (state == SHIFT && last) begin
         data_q <= {upper, mirror};
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == HOLD);
   assign bus.busy      = (state != IDLE);
   assign bus.data_out  = data_q;

   a_out_is_palindrome: assert property (@(posedge clk) disable iff (rst)
      bus.out_valid |-> is_palindrome(MAX_W'(bus.data_out), WIDTH));

endmodule

// File: tb/tb_palindrome_generator.sv
// Bench for palindrome_generator at WIDTH=8 and WIDTH=16 with a queue-based reference model.
module tb_palindrome_generator;
   import palindrome_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   palindrome_if #(.WIDTH(8))  b8 ();
   palindrome_if #(.WIDTH(16)) b16 ();

   palindrome_generator #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
   palindrome_generator #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: upper half is the input, lower half is its bit reversal.
   function automatic logic [63:0] model_word(input logic [63:0] half, input int width);
      logic [63:0] w;
      int hw;
      hw = width / 2;
      w  = '0;
      for (int i = 0; i < hw; i++) begin
         w[hw + i]     = half[i];
         w[hw - 1 - i] = half[i];
      end
      return w;
   endfunction

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   logic        ov [2];
   logic        ordy [2];
   logic        iv [2];
   logic        irdy [2];
   logic [63:0] dout [2];
   logic [63:0] hin [2];
   int          wd [2] = '{8, 16};

   assign ov[0]   = b8.out_valid;   assign ov[1]   = b16.out_valid;
   assign ordy[0] = b8.out_ready;   assign ordy[1] = b16.out_ready;
   assign iv[0]   = b8.in_valid;    assign iv[1]   = b16.in_valid;
   assign irdy[0] = b8.in_ready;    assign irdy[1] = b16.in_ready;
   assign dout[0] = 64'(b8.data_out);
   assign dout[1] = 64'(b16.data_out);
   assign hin[0]  = 64'(b8.half_in);
   assign hin[1]  = 64'(b16.half_in);

   logic [63:0] exp_q [2][$];
   int          accepted [2] = '{0, 0};
   int          emitted  [2] = '{0, 0};
   logic        hold_prev [2] = '{1'b0, 1'b0};
   logic [63:0] dout_prev [2];

   // Scoreboard: handshakes observed mid-cycle complete on the next rising edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            exp_q[d].delete();
            hold_prev[d] = 1'b0;
         end else begin
            if (hold_prev[d]) begin
               check("hold_valid", 64'(ov[d]), 1);
               check("hold_stable", dout[d], dout_prev[d]);
            end
            if (iv[d] && irdy[d]) begin
               exp_q[d].push_back(model_word(hin[d], wd[d]));
               accepted[d]++;
            end
            if (ov[d] && ordy[d]) begin
               check("sb_pending", 64'(exp_q[d].size() > 0), 1);
               if (exp_q[d].size() > 0) check("sb_word", dout[d], exp_q[d].pop_front());
               check("sb_is_pal", 64'(is_palindrome(dout[d], wd[d])), 1);
               emitted[d]++;
            end
            hold_prev[d] = ov[d] && !ordy[d];
            dout_prev[d] = dout[d];
         end
      end
   end

   task automatic send(input int d, input logic [7:0] h);
      int waited;
      logic got;
      waited = 0;
      got    = 1'b0;
      if (d == 0) begin b8.half_in = h[3:0]; b8.in_valid = 1'b1; end
      else        begin b16.half_in = h;     b16.in_valid = 1'b1; end
      while (!got && waited < 200) begin
         got = (d == 0) ? b8.in_ready : b16.in_ready;
         step();
         waited++;
      end
      if (d == 0) b8.in_valid = 1'b0;
      else        b16.in_valid = 1'b0;
      check("send_accepted", 64'(got), 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, second, nv;
      logic seen;
      bit done8, done16;

      rst = 1'b1;
      b8.in_valid  = 1'b0; b8.half_in  = '0; b8.out_ready  = 1'b0;
      b16.in_valid = 1'b0; b16.half_in = '0; b16.out_ready = 1'b0;
      step(2);
      check("rst_in_ready", 64'(b8.in_ready), 0);
      check("rst_out_valid", 64'(b8.out_valid), 0);
      check("rst_busy", 64'(b8.busy), 0);
      check("rst_data", 64'(b8.data_out), 0);
      check("rst_data16", 64'(b16.data_out), 0);
      rst = 1'b0;
      #1;
      check("rel_in_ready", 64'(b8.in_ready), 1);

      // Basic
      b8.half_in = 4'b1011; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      step();
      b8.in_valid = 1'b0;
      check("basic_busy", 64'(b8.busy), 1);
      check("basic_in_ready", 64'(b8.in_ready), 0);
      step(3);
      check("basic_early", 64'(b8.out_valid), 0);
      step();
      check("basic_valid", 64'(b8.out_valid), 1);
      check("basic_data", 64'(b8.data_out), 64'h BD);
      check("basic_pal", 64'(is_palindrome(64'(b8.data_out), 8)), 1);
      step();
      check("basic_done_valid", 64'(b8.out_valid), 0);
      check("basic_done_ready", 64'(b8.in_ready), 1);
      check("basic_retain", 64'(b8.data_out), 64'h BD);

      // Backpressure
      b8.half_in = 4'b0001; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
      step();
      b8.in_valid = 1'b0;
      step(4);
      b8.half_in = 4'hE; b8.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 64'(b8.out_valid), 1);
         check("bp_data", 64'(b8.data_out), 64'h18);
         check("bp_in_ready", 64'(b8.in_ready), 0);
         step();
      end
      b8.in_valid = 1'b0; b8.out_ready = 1'b1;
      step();
      check("bp_release_valid", 64'(b8.out_valid), 0);
      check("bp_release_ready", 64'(b8.in_ready), 1);

      // Back-to-back
      b8.half_in = 4'hA; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
      step();
      b8.half_in = 4'h3;
      first = -1; second = -1; nv = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 6) b8.in_valid = 1'b0;
         if (b8.out_valid) begin
            if (nv == 0) begin
               first = k;
               check("b2b_first", 64'(b8.data_out), 64'h A5);
            end else begin
               second = k;
               check("b2b_second", 64'(b8.data_out), 64'h3C);
            end
            nv++;
         end
      end
      check("b2b_count", 64'(nv), 2);
      check("b2b_first_at", 64'(first), 4);
      check("b2b_spacing", 64'(second - first), 6);

      // Reset mid-SHIFT
      b8.half_in = 4'hF; b8.in_valid = 1'b1;
      step();
      b8.in_valid = 1'b0;
      step(2);
      rst = 1'b1;
      #1;
      check("midrst_valid", 64'(b8.out_valid), 0);
      check("midrst_busy", 64'(b8.busy), 0);
      check("midrst_data", 64'(b8.data_out), 0);
      check("midrst_in_ready", 64'(b8.in_ready), 0);
      step();
      rst = 1'b0;
      #1;
      check("midrst_ready_after", 64'(b8.in_ready), 1);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (b8.out_valid) seen = 1'b1;
      end
      check("midrst_no_emit", 64'(seen), 0);

      // Random sweep on both widths with random backpressure
      done8 = 1'b0; done16 = 1'b0;
      fork
         begin
            for (int n = 0; n < 1000; n++) begin
               step($urandom_range(0, 2));
               send(0, 8'($urandom_range(0, 15)));
            end
            done8 = 1'b1;
         end
         begin
            for (int n = 0; n < 1000; n++) begin
               step($urandom_range(0, 2));
               send(1, 8'($urandom_range(0, 255)));
            end
            done16 = 1'b1;
         end
         begin
            while (!(done8 && done16)) begin
               b8.out_ready  = ($urandom_range(0, 3) != 0);
               b16.out_ready = ($urandom_range(0, 3) != 0);
               step();
            end
         end
      join
      b8.out_ready = 1'b1; b16.out_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q[0].size() > 0 || exp_q[1].size() > 0); i++) step();
      step(2);
      check("drain8", 64'(exp_q[0].size()), 0);
      check("drain16", 64'(exp_q[1].size()), 0);
      check("accepted8", 64'(accepted[0]), 1005);
      check("accepted16", 64'(accepted[1]), 1000);
      check("emitted8", 64'(emitted[0]), 1004);
      check("emitted16", 64'(emitted[1]), 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
